// File: rtl/reg_bank_nbit.sv
// Bank of DEPTH registers of WIDTH bits with load/inc/dec/shl writes, carry/zero flags and a tristate read bus.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BANK_NBIT_FWD_EN.
module reg_bank_nbit #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SELW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [WIDTH-1:0] in,
    input  logic             low_i_en,
    input  logic             low_o_en,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [SELW-1:0]  rd_sel,
    input  logic [1:0]       op,
    output tri   [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             wr_in_range;
    logic             wr_valid;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] result;
    logic             res_carry;
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        wr_in_range = 1'b0;
        old_val     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel == SELW'(i)) begin
                wr_in_range = 1'b1;
                old_val     = regs_q[i];
            end
        end
        wr_valid = !low_i_en && wr_in_range;
    end

    always_comb begin
        result    = in;
        res_carry = 1'b0;
        case (op)
            OP_LOAD: begin
                result    = in;
                res_carry = 1'b0;
            end
            OP_INC: begin
                result    = old_val + WIDTH'(1);
                res_carry = &old_val;
            end
            OP_DEC: begin
                result    = old_val - WIDTH'(1);
                res_carry = ~|old_val;
            end
            OP_SHL: begin
                result    = {old_val[WIDTH-2:0], 1'b0};
                res_carry = old_val[WIDTH-1];
            end
            default: begin
                result    = in;
                res_carry = 1'b0;
            end
        endcase
    end

    // Reset is applied in the register process, so this only describes the write path.
    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (wr_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel == SELW'(i)) begin
                    regs_d[i] = result;
                end
            end
            carry_d = res_carry;
            zero_d  = (result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            carry_q <= 1'b0;
            zero_q  <= (RESET_VAL == '0);
        end else begin
            regs_q  <= regs_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel == SELW'(i)) begin
                rd_word = regs_q[i];
            end
        end
`ifdef REG_BANK_NBIT_FWD_EN
        // A pending write to the selected register is shown before it lands.
        if (wr_valid && !sync_reset && (rd_sel == wr_sel)) begin
            rd_word = result;
        end
`endif
    end

    assign out   = low_o_en ? {WIDTH{1'bz}} : rd_word;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_reg_bank_nbit.sv
// Scoreboard bench for reg_bank_nbit: two instances (DEPTH=4 and DEPTH=3) share stimulus and are
// checked against an arithmetic reference model; the read buses are pulled up so a released bus reads all-ones.
module tb_reg_bank_nbit;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       sync_reset;
    logic       low_i_en;
    logic       low_o_en;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic [1:0] op;
    logic [7:0] din;
    tri1  [7:0] out_a;
    tri1  [7:0] out_b;
    logic       carry_a, zero_a, carry_b, zero_b;

    reg_bank_nbit #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) u_a (
        .clk(clk), .sync_reset(sync_reset), .in(din), .low_i_en(low_i_en), .low_o_en(low_o_en),
        .wr_sel(wr_sel), .rd_sel(rd_sel), .op(op), .out(out_a), .carry(carry_a), .zero(zero_a)
    );

    reg_bank_nbit #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) u_b (
        .clk(clk), .sync_reset(sync_reset), .in(din), .low_i_en(low_i_en), .low_o_en(low_o_en),
        .wr_sel(wr_sel), .rd_sel(rd_sel), .op(op), .out(out_b), .carry(carry_b), .zero(zero_b)
    );

    typedef struct {
        int              tag;
        logic [1:0][7:0] out;
        logic [1:0]      c;
        logic [1:0]      z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag   = 0;

    // Reference model: index 0 is the DEPTH=4 bank, index 1 the DEPTH=3 bank.
    int mdl[2][4];
    int mc[2];
    int mz[2];

    function automatic int depth_of(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int wres(int old, int o, int d);
        case (o)
            0:       return d;
            1:       return (old + 1) % 256;
            2:       return (old + 255) % 256;
            default: return (old * 2) % 256;
        endcase
    endfunction

    function automatic int wcar(int old, int o);
        case (o)
            0:       return 0;
            1:       return (old == 255) ? 1 : 0;
            2:       return (old == 0) ? 1 : 0;
            default: return (old >= 128) ? 1 : 0;
        endcase
    endfunction

    task automatic cycle(input logic rst, input logic ien, input logic oen,
                         input int ws, input int rs, input int o, input int d, input bit push = 1'b1);
        exp_t e;
        sync_reset = rst;
        low_i_en   = ien;
        low_o_en   = oen;
        wr_sel     = 2'(ws);
        rd_sel     = 2'(rs);
        op         = 2'(o);
        din        = 8'(d);
        if (push) begin
            e.tag = tag;
            for (int k = 0; k < 2; k++) begin
                int v;
                if (oen)                 v = 255;
                else if (rs >= depth_of(k)) v = 0;
                else                     v = mdl[k][rs];
`ifdef REG_BANK_NBIT_FWD_EN
                if (!oen && !ien && !rst && ws == rs && ws < depth_of(k))
                    v = wres(mdl[k][ws], o, d);
`endif
                e.out[k] = 8'(v);
                e.c[k]   = mc[k][0];
                e.z[k]   = mz[k][0];
            end
            sb.push_back(e);
            tag++;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) mdl[k][i] = int'(RV);
                mc[k] = 0;
                mz[k] = (RV == 0) ? 1 : 0;
            end else if (!ien && ws < depth_of(k)) begin
                int old;
                old           = mdl[k][ws];
                mdl[k][ws]    = wres(old, o, d);
                mc[k]         = wcar(old, o);
                mz[k]         = (mdl[k][ws] == 0) ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic chk(input string nm, input int t, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s entry %0d: got %h expected %h", nm, t, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_a",   e.tag, out_a,          e.out[0]);
            chk("carry_a", e.tag, {7'd0, carry_a}, {7'd0, e.c[0]});
            chk("zero_a",  e.tag, {7'd0, zero_a},  {7'd0, e.z[0]});
            chk("out_b",   e.tag, out_b,          e.out[1]);
            chk("carry_b", e.tag, {7'd0, carry_b}, {7'd0, e.c[1]});
            chk("zero_b",  e.tag, {7'd0, zero_b},  {7'd0, e.z[1]});
        end
    end

    initial begin
        sync_reset = 1'b0; low_i_en = 1'b1; low_o_en = 1'b1;
        wr_sel = '0; rd_sel = '0; op = '0; din = '0;
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mz[k] = 0;
            for (int i = 0; i < 4; i++) mdl[k][i] = 0;
        end
        @(posedge clk); #1;
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, i, 0, 0);
        // Dirty some registers, then reset with a colliding write of FF to reg1.
        cycle(0, 0, 0, 0, 0, 0, 8'h11);
        cycle(0, 0, 0, 1, 1, 0, 8'h22);
        cycle(0, 0, 0, 2, 2, 0, 8'h80);
        cycle(0, 0, 0, 2, 2, 3, 0);
        cycle(1, 0, 0, 1, 1, 0, 8'hFF);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, i, 0, 0);
        // Increment wrap on reg2.
        cycle(0, 0, 0, 2, 2, 0, 8'hFF);
        cycle(0, 0, 0, 2, 2, 1, 8'h55);
        cycle(0, 0, 0, 2, 2, 1, 8'h55);
        cycle(0, 1, 0, 0, 2, 0, 0);
        // Decrement borrow on reg0, shift out MSB on reg3 (ignored by the 3-deep bank).
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 2, 8'h77);
        cycle(0, 0, 0, 3, 3, 0, 8'h81);
        cycle(0, 0, 0, 3, 3, 3, 8'h00);
        cycle(0, 1, 0, 0, 3, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        // Released bus, out-of-range read and write.
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 3, 0, 0);
        cycle(0, 0, 0, 3, 3, 0, 8'h00);
        cycle(0, 1, 0, 0, 3, 0, 0);
        // Same-cycle read and write of reg1.
        cycle(0, 0, 0, 1, 1, 0, 8'h3C);
        cycle(0, 1, 0, 0, 1, 0, 0);
        // Carry set, then five idle cycles with a reset pulse-free bus sweep.
        cycle(0, 0, 0, 0, 0, 0, 8'hFF);
        cycle(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, $urandom_range(0, 3), i % 4, $urandom_range(0, 3), $urandom_range(0, 255));
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
        end
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
